uart_rx_irq: RTL and testbench
==============================

UART_RX_IRQ -- requirements
Module: uart_rx_irq

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning CLK cycles per serial bit (8N1; legal minimum 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of 2).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port RXD  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port IRQ_EN  input  1  external-interrupt enable from the CSR side.
REQ-007 SHALL have port RD_EN  input  1  pop request for the FIFO head.
REQ-008 SHALL have port ERR_CLR  input  1  clears FRAME_ERR and OVERRUN.
REQ-009 SHALL have port RX_DATA  output  8  FIFO head byte; valid only when RX_VALID=1.
REQ-010 SHALL have port RX_VALID  output  1  FIFO non-empty.
REQ-011 SHALL have port UART  output  1  external-interrupt request, driving the trap handler's EXTERNAL input.
REQ-012 SHALL have port FRAME_ERR  output  1  sticky stop-bit error flag.
REQ-013 SHALL have port OVERRUN  output  1  sticky byte-dropped-on-full flag.

Function
REQ-014 SHALL pass RXD through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP with one bit-timer (0..CLKS_PER_BIT-1) and a 3-bit bit index.
REQ-016 IDLE: on a synchronized high-to-low transition, go to START with the timer cleared.
REQ-017 START: at timer = CLKS_PER_BIT/2 (integer division), sample; 0 -> DATA with timer cleared; 1 (glitch) -> IDLE, no byte, no flag.
REQ-018 DATA: sample every CLKS_PER_BIT cycles; shift LSB-first into an 8-bit register; after bit index 7 -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte; 0 -> drop byte and set FRAME_ERR; then IDLE.
REQ-020 In IDLE after a framing error, SHALL NOT start a new frame until the synchronized line has been seen high for at least one cycle.
REQ-021 Push SHALL occur in the cycle after the stop-bit sample; RX_VALID rises that same cycle.
REQ-022 FIFO SHALL be first-word-fall-through: RX_DATA shows the oldest byte without any read.
REQ-023 RD_EN with RX_VALID=1 pops one entry; RD_EN with RX_VALID=0 SHALL be ignored.
REQ-024 Push while full and no pop in that cycle: byte dropped, OVERRUN set, FIFO contents unchanged.
REQ-025 Simultaneous push and pop while full: both performed, occupancy unchanged, OVERRUN not set.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be log2(FIFO_DEPTH)+1.
REQ-027 UART SHALL be registered: UART(next) = IRQ_EN AND (FIFO non-empty after this cycle's push/pop); level, not pulse.
REQ-028 ERR_CLR clears both flags; when a set event coincides with ERR_CLR, set SHALL win.

Reset
REQ-029 RESET_N low SHALL immediately force: FSM=IDLE, timer/index=0, FIFO empty, RX_VALID=0, RX_DATA=0, UART=0, FRAME_ERR=0, OVERRUN=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL discard the partial byte; first frame after release SHALL need a fresh falling edge.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (2-bit) and the 8N1 constants (data bits=8, stop bits=1).
REQ-032 FIFO SHALL be a separate sub-module rx_byte_fifo (push/pop/full/empty/head); FSM and flags stay in uart_rx_irq.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-033 Send 0xA5 with IRQ_EN=1 -> RX_VALID=1, RX_DATA=0xA5 one cycle after stop sample; UART=1 next cycle; RD_EN pulse -> RX_VALID=0, UART=0.
REQ-034 RXD low for 3 cycles then high -> no push, FSM returns to IDLE, flags stay 0.
REQ-035 Send 0x3C with stop bit 0 -> FRAME_ERR=1, RX_VALID=0; ERR_CLR -> FRAME_ERR=0.
REQ-036 Send 0x01..0x05 without reads -> OVERRUN=1; reads return 0x01,0x02,0x03,0x04, then RX_VALID=0.
REQ-037 FIFO full, RD_EN asserted in the push cycle of 0x05 -> OVERRUN=0; subsequent reads return 0x02..0x05.
REQ-038 RESET_N pulse at DATA bit 4 of 0xFF -> all outputs 0 immediately; next clean 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_rx_irq_pkg.sv
// Shared definitions for the 8N1 interrupt-driven UART receiver:
// frame constants and the receive FSM state encoding.
package uart_rx_irq_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef logic [DATA_BITS-1:0] rx_byte_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_irq_if.sv
// Interfaces for the UART receiver: the internal byte-FIFO handshake and the
// CSR-side signal bundle that a host/bench drives and observes.
interface rx_fifo_if;
  import uart_rx_irq_pkg::*;

  logic     push;
  logic     pop;
  rx_byte_t push_data;
  logic     full;
  logic     valid;
  logic     dropped;
  logic     nonempty_next;
  rx_byte_t head;

  modport master (output push, pop, push_data,
                  input  full, valid, dropped, nonempty_next, head);
  modport slave  (input  push, pop, push_data,
                  output full, valid, dropped, nonempty_next, head);
endinterface

interface uart_rx_irq_if;
  logic       rxd;
  logic       irq_en;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uart;
  logic       frame_err;
  logic       overrun;

  modport master (output rxd, irq_en, rd_en, err_clr,
                  input  rx_data, rx_valid, uart, frame_err, overrun);
  modport slave  (input  rxd, irq_en, rd_en, err_clr,
                  output rx_data, rx_valid, uart, frame_err, overrun);
endinterface

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO for received UART bytes; DEPTH must be a
// power of two (>= 2). A push becomes visible at the head in its own cycle.
module rx_byte_fifo
  import uart_rx_irq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  rx_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_byte_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign bus.full = (count == (AW+1)'(DEPTH));

  // The pending push is bypassed to the head so valid rises in the push cycle;
  // an empty FIFO with push+pop writes and consumes the same slot.
  assign bus.valid   = !empty || bus.push;
  assign bus.head    = !empty ? mem[rd_ptr] : (bus.push ? bus.push_data : '0);
  assign do_pop      = bus.pop && bus.valid;
  assign do_push     = bus.push && (!bus.full || do_pop);
  assign bus.dropped = bus.push && !do_push;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  assign bus.nonempty_next = (count_next != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.push_data;
  end

endmodule

// File: rtl/uart_rx_irq.sv
// 8N1 UART receiver with a byte FIFO, sticky framing/overrun flags and a
// level-sensitive external interrupt request.
module uart_rx_irq
  import uart_rx_irq_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RXD,
  input  logic       IRQ_EN,
  input  logic       RD_EN,
  input  logic       ERR_CLR,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       UART,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int unsigned   TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT  = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_e     state;
  rx_state_e     state_next;
  logic          sync1;
  logic          sync2;
  logic          rx_prev;
  logic          rx;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  rx_byte_t      shreg;
  logic          push_q;
  logic          half;
  logic          tick;
  logic          timer_run;
  logic          shift_en;
  logic          stop_sample;

  rx_fifo_if fifo_bus ();

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= RXD;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign rx   = sync2;
  assign half = (timer == HALF_BIT);
  assign tick = (timer == LAST_TICK);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_next;
  end

  // A start needs a high-to-low edge of the synchronized line, so after a
  // framing error with the line still low no frame begins until it goes high.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (rx_prev && !rx)                 state_next = S_START;
      S_START: if (half)                           state_next = rx ? S_IDLE : S_DATA;
      S_DATA:  if (tick && (bit_idx == LAST_BIT))  state_next = S_STOP;
      S_STOP:  if (tick)                           state_next = S_IDLE;
      default:                                     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    timer_run   = 1'b0;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_START: timer_run = !half;
      S_DATA: begin
        timer_run = !tick;
        shift_en  = tick;
      end
      S_STOP: begin
        timer_run   = !tick;
        stop_sample = tick;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
    end else begin
      timer  <= timer_run ? timer + 1'b1 : '0;
      push_q <= stop_sample && rx;
      if (state == S_IDLE)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;
      if (shift_en)
        shreg <= {rx, shreg[DATA_BITS-1:1]};
    end
  end

  assign fifo_bus.push      = push_q;
  assign fifo_bus.push_data = shreg;
  assign fifo_bus.pop       = RD_EN;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .bus   (fifo_bus)
  );

  assign RX_DATA  = fifo_bus.head;
  assign RX_VALID = fifo_bus.valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      UART      <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      UART      <= IRQ_EN && fifo_bus.nonempty_next;
      FRAME_ERR <= (stop_sample && !rx) || (FRAME_ERR && !ERR_CLR);
      OVERRUN   <= fifo_bus.dropped || (OVERRUN && !ERR_CLR);
    end
  end

endmodule

// File: tb/tb_uart_rx_irq.sv
// Directed bench for uart_rx_irq at CLKS_PER_BIT=8, FIFO_DEPTH=4. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_uart_rx_irq;
  import uart_rx_irq_pkg::*;

  localparam int unsigned CPB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_rx_irq_if io ();

  uart_rx_irq #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .RXD       (io.rxd),
    .IRQ_EN    (io.irq_en),
    .RD_EN     (io.rd_en),
    .ERR_CLR   (io.err_clr),
    .RX_DATA   (io.rx_data),
    .RX_VALID  (io.rx_valid),
    .UART      (io.uart),
    .FRAME_ERR (io.frame_err),
    .OVERRUN   (io.overrun)
  );

  always #5 clk = ~clk;

  // Drives one frame starting at the current falling edge and returns on the
  // falling edge just after the stop bit (80 edges at CPB=8); seen reports
  // whether RX_VALID was high at any earlier edge of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, output logic seen);
    int unsigned nbits;
    int unsigned k;
    logic v;
    nbits = 1 + DATA_BITS + STOP_BITS;
    seen  = 1'b0;
    k     = 0;
    for (int i = 0; i < int'(nbits); i++) begin
      if (i == 0)                  v = 1'b0;
      else if (i <= int'(DATA_BITS)) v = b[i-1];
      else                         v = stop_val;
      io.rxd = v;
      for (int j = 0; j < int'(CPB); j++) begin
        @(negedge clk);
        k++;
        if (k < nbits * CPB) seen = seen | io.rx_valid;
      end
    end
  endtask

  task automatic test_reset();
    io.rxd = 1'b1; io.irq_en = 1'b0; io.rd_en = 1'b0; io.err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", io.rx_valid); end
    checks++; if (io.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", io.rx_data); end
    checks++; if (io.uart !== 1'b0) begin errors++; $display("FAIL reset_uart: got %b want 0", io.uart); end
    checks++; if (io.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", io.frame_err); end
    checks++; if (io.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", io.overrun); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", io.rx_valid); end
  endtask

  task automatic test_single_byte();
    logic seen;
    io.irq_en = 1'b1;
    send_frame(8'hA5, 1'b1, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", seen); end
    checks++; if (io.rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", io.rx_valid); end
    checks++; if (io.rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", io.rx_data); end
    checks++; if (io.uart !== 1'b0) begin errors++; $display("FAIL single_uart_lag: got %b want 0", io.uart); end
    @(negedge clk);
    checks++; if (io.uart !== 1'b1) begin errors++; $display("FAIL single_uart: got %b want 1", io.uart); end
    io.rd_en = 1'b1;
    @(negedge clk);
    io.rd_en = 1'b0;
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", io.rx_valid); end
    checks++; if (io.uart !== 1'b0) begin errors++; $display("FAIL single_pop_uart: got %b want 0", io.uart); end
    io.rd_en = 1'b1;
    @(negedge clk);
    io.rd_en = 1'b0;
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_ignored: got %b want 0", io.rx_valid); end
  endtask

  task automatic test_glitch();
    logic seen;
    io.rxd = 1'b0;
    repeat (3) @(negedge clk);
    io.rxd = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", io.rx_valid); end
    checks++; if (io.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b want 0", io.frame_err); end
    checks++; if (io.overrun !== 1'b0) begin errors++; $display("FAIL glitch_ovr: got %b want 0", io.overrun); end
    send_frame(8'hC3, 1'b1, seen);
    checks++; if (io.rx_data !== 8'hC3 || io.rx_valid !== 1'b1) begin errors++; $display("FAIL glitch_next_frame: got %h/%b want c3/1", io.rx_data, io.rx_valid); end
    io.rd_en = 1'b1;
    @(negedge clk);
    io.rd_en = 1'b0;
  endtask

  task automatic test_frame_error();
    logic seen;
    io.err_clr = 1'b1;
    send_frame(8'h3C, 1'b0, seen);
    io.err_clr = 1'b0;
    checks++; if (io.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set_wins: got %b want 1", io.frame_err); end
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_push: got %b want 0", io.rx_valid); end
    io.rxd = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (io.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", io.frame_err); end
    io.err_clr = 1'b1;
    @(negedge clk);
    io.err_clr = 1'b0;
    checks++; if (io.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", io.frame_err); end
  endtask

  task automatic test_overrun();
    logic seen;
    logic [7:0] want;
    io.irq_en = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, seen);
    @(negedge clk);
    checks++; if (io.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", io.overrun); end
    checks++; if (io.uart !== 1'b0) begin errors++; $display("FAIL ovr_irq_masked: got %b want 0", io.uart); end
    for (int i = 1; i <= 4; i++) begin
      want = 8'(i);
      checks++; if (io.rx_valid !== 1'b1 || io.rx_data !== want) begin errors++; $display("FAIL ovr_read%0d: got %h/%b want %h/1", i, io.rx_data, io.rx_valid, want); end
      io.rd_en = 1'b1;
      @(negedge clk);
      io.rd_en = 1'b0;
    end
    checks++; if (io.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b want 0", io.rx_valid); end
    io.err_clr = 1'b1;
    @(negedge clk);
    io.err_clr = 1'b0;
    checks++; if (io.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", io.overrun); end
  endtask

  task automatic test_full_push_pop();
    logic seen;
    logic [7:0] want;
    io.irq_en = 1'b1;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, seen);
    @(negedge clk);
    checks++; if (io.uart !== 1'b1) begin errors++; $display("FAIL full_uart: got %b want 1", io.uart); end
    send_frame(8'h05, 1'b1, seen);
    io.rd_en = 1'b1;
    @(negedge clk);
    io.rd_en = 1'b0;
    checks++; if (io.overrun !== 1'b0) begin errors++; $display("FAIL pushpop_no_ovr: got %b want 0", io.overrun); end
    for (int i = 2; i <= 5; i++) begin
      want = 8'(i);
      checks++; if (io.rx_valid !== 1'b1 || io.rx_data !== want) begin errors++; $display("FAIL pushpop_read%0d: got %h/%b want %h/1", i, io.rx_data, io.rx_valid, want); end
      io.rd_en = 1'b1;
      @(negedge clk);
      io.rd_en = 1'b0;
    end
    checks++; if (io.rx_valid !== 1'b0 || io.uart !== 1'b0) begin errors++; $display("FAIL pushpop_drained: got valid %b uart %b want 0/0", io.rx_valid, io.uart); end
  endtask

  task automatic test_reset_mid_frame();
    logic seen;
    send_frame(8'h11, 1'b0, seen);
    io.rxd = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h22, 1'b1, seen);
    @(negedge clk);
    checks++; if (io.rx_valid !== 1'b1 || io.frame_err !== 1'b1 || io.uart !== 1'b1) begin errors++; $display("FAIL mid_pre_state: got valid %b ferr %b uart %b want 1/1/1", io.rx_valid, io.frame_err, io.uart); end
    io.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    io.rxd = 1'b1;
    repeat (CPB * 4 + 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (io.rx_valid !== 1'b0 || io.rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_fifo: got %h/%b want 00/0", io.rx_data, io.rx_valid); end
    checks++; if (io.uart !== 1'b0 || io.frame_err !== 1'b0 || io.overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got uart %b ferr %b ovr %b want 0/0/0", io.uart, io.frame_err, io.overrun); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 8) @(negedge clk);
    checks++; if (io.rx_valid !== 1'b0 || io.frame_err !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got valid %b ferr %b want 0/0", io.rx_valid, io.frame_err); end
    send_frame(8'h5A, 1'b1, seen);
    checks++; if (io.rx_valid !== 1'b1 || io.rx_data !== 8'h5A) begin errors++; $display("FAIL mid_next_frame: got %h/%b want 5a/1", io.rx_data, io.rx_valid); end
    io.rd_en = 1'b1;
    @(negedge clk);
    io.rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
